// File: rtl/draw_paddle_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg / vga_if
// Brief    : Video timing constants and the pixel-stream bundle shared by the
//            PONG pipeline stages (timing counters, sync, blanking, colour).
// Revision : 1.0 - initial release
// ============================================================================

package vga_pkg;
  localparam int VER_PIXELS = 600;
endpackage

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  // Consumer side of a pipeline link.
  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  // Producer side of a pipeline link.
  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

`default_nettype wire

// File: rtl/draw_paddle.sv
`default_nettype none
// ============================================================================
// Module   : draw_paddle
// Brief    : Overlays a solid paddle rectangle on the video stream and moves
//            it vertically once per frame from two push buttons, with
//            hold-to-accelerate speed and clamping to the visible area.
// Revision : 1.0 - initial release
// ============================================================================

module draw_paddle
  import vga_pkg::*;
#(
  parameter int          X_POS        = 30,
  parameter int          WIDTH        = 15,
  parameter int          HEIGHT       = 100,
  parameter logic [11:0] COLOR        = 12'hfff,
  parameter int          Y_INIT       = 250,
  parameter int          SCREEN_H     = VER_PIXELS,
  parameter int          SPEED_MIN    = 4,
  parameter int          SPEED_STEP   = 4,
  parameter int          SPEED_MAX    = 16,
  parameter int          ACCEL_FRAMES = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        btn_up,
  input  wire logic        btn_down,
  vga_if.in                vga,
  vga_if.out               vga_out,
  output logic [10:0]      paddle_y
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic [11:0] C_X_LO       = 12'(X_POS);
  localparam logic [11:0] C_X_HI       = 12'(X_POS + WIDTH);
  localparam logic [11:0] C_HEIGHT     = 12'(HEIGHT);
  localparam logic [11:0] C_Y_LIMIT    = 12'(SCREEN_H - HEIGHT);
  localparam logic [10:0] C_Y_INIT     = 11'(Y_INIT);
  localparam logic [10:0] C_SPEED_MIN  = 11'(SPEED_MIN);
  localparam logic [11:0] C_SPEED_STEP = 12'(SPEED_STEP);
  localparam logic [11:0] C_SPEED_MAX  = 12'(SPEED_MAX);
  localparam logic [15:0] C_ACCEL_LAST = 16'(ACCEL_FRAMES - 1);

  logic        r_up_meta, r_up_sync;
  logic        r_down_meta, r_down_sync;
  logic        r_vblnk_prev;
  state_t      r_state;
  logic [10:0] r_speed;
  logic [15:0] r_cnt;
  logic [10:0] r_y;

  logic               w_tick;
  state_t             w_dir_next;
  logic               w_continue;
  logic [10:0]        w_step;
  logic signed [11:0] w_y_up_s;
  logic [10:0]        w_y_up;
  logic [11:0]        w_y_dn_sum;
  logic [10:0]        w_y_dn;
  logic [15:0]        w_cnt_inc;
  logic [11:0]        w_speed_sum;
  logic [10:0]        w_speed_acc;
  logic               w_in_x;
  logic               w_in_y;
  logic               w_draw;

  // Two-flop button synchronisers and the previous-vblnk flop for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_up_meta    <= 1'b0;
      r_up_sync    <= 1'b0;
      r_down_meta  <= 1'b0;
      r_down_sync  <= 1'b0;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_up_meta    <= btn_up;
      r_up_sync    <= r_up_meta;
      r_down_meta  <= btn_down;
      r_down_sync  <= r_down_meta;
      r_vblnk_prev <= vga.vblnk;
    end
  end

  // Frame tick on vertical-blank entry; direction decode and motion maths.
  always_comb begin
    w_tick     = vga.vblnk & ~r_vblnk_prev;
    w_dir_next = ST_IDLE;
    if (r_up_sync && !r_down_sync) begin
      w_dir_next = ST_UP;
    end else if (r_down_sync && !r_up_sync) begin
      w_dir_next = ST_DOWN;
    end
    // A fresh direction always starts at the minimum speed.
    w_continue  = (w_dir_next == r_state) && (w_dir_next != ST_IDLE);
    w_step      = w_continue ? r_speed : C_SPEED_MIN;
    w_y_up_s    = $signed({1'b0, r_y}) - $signed({1'b0, w_step});
    w_y_up      = w_y_up_s[11] ? 11'd0 : w_y_up_s[10:0];
    w_y_dn_sum  = {1'b0, r_y} + {1'b0, w_step};
    w_y_dn      = (w_y_dn_sum > C_Y_LIMIT) ? C_Y_LIMIT[10:0] : w_y_dn_sum[10:0];
    w_cnt_inc   = r_cnt + 16'd1;
    w_speed_sum = {1'b0, r_speed} + C_SPEED_STEP;
    w_speed_acc = (w_speed_sum > C_SPEED_MAX) ? C_SPEED_MAX[10:0] : w_speed_sum[10:0];
  end

  // Direction FSM, speed/acceleration and position; all change only at a tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_speed <= C_SPEED_MIN;
      r_cnt   <= 16'd0;
      r_y     <= C_Y_INIT;
    end else if (w_tick) begin
      r_state <= w_dir_next;
      if (w_dir_next == ST_UP) begin
        r_y <= w_y_up;
      end else if (w_dir_next == ST_DOWN) begin
        r_y <= w_y_dn;
      end
      if (w_continue) begin
        if (w_cnt_inc >= C_ACCEL_LAST) begin
          r_cnt   <= 16'd0;
          r_speed <= w_speed_acc;
        end else begin
          r_cnt   <= w_cnt_inc;
        end
      end else begin
        r_cnt   <= 16'd0;
        r_speed <= C_SPEED_MIN;
      end
    end
  end

  // Half-open rectangle test against the incoming (undelayed) counters.
  always_comb begin
    w_in_x = ({1'b0, vga.hcount} >= C_X_LO) && ({1'b0, vga.hcount} < C_X_HI);
    w_in_y = ({1'b0, vga.vcount} >= {1'b0, r_y}) &&
             ({1'b0, vga.vcount} < ({1'b0, r_y} + C_HEIGHT));
    w_draw = w_in_x && w_in_y && !vga.hblnk && !vga.vblnk;
  end

  // One-cycle registered pass-through with the paddle colour overlaid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= 11'd0;
      vga_out.vcount <= 11'd0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= 12'd0;
    end else begin
      vga_out.hcount <= vga.hcount;
      vga_out.vcount <= vga.vcount;
      vga_out.hsync  <= vga.hsync;
      vga_out.vsync  <= vga.vsync;
      vga_out.hblnk  <= vga.hblnk;
      vga_out.vblnk  <= vga.vblnk;
      vga_out.rgb    <= w_draw ? COLOR : vga.rgb;
    end
  end

  assign paddle_y = r_y;

endmodule

`default_nettype wire

// File: tb/tb_draw_paddle.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_paddle
// Brief    : Directed self-checking bench for draw_paddle (default params).
// Revision : 1.0 - initial release
// ============================================================================

module tb_draw_paddle;

  logic        clk;
  logic        rst;
  logic        btn_up;
  logic        btn_down;
  logic [10:0] paddle_y;
  logic [10:0] r_prev;

  int total;
  int bad;

  vga_if u_vga_in();
  vga_if u_vga_out();

  draw_paddle u_dut (
    .clk      (clk),
    .rst      (rst),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .vga      (u_vga_in),
    .vga_out  (u_vga_out),
    .paddle_y (paddle_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame tick: vblnk rises for one cycle, paddle_y valid afterwards.
  task automatic tick();
    u_vga_in.vblnk = 1'b1;
    step(1);
    u_vga_in.vblnk = 1'b0;
    step(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_px(input logic [10:0] h, input logic [10:0] v);
    u_vga_in.hcount = h;
    u_vga_in.vcount = v;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    btn_up = 1'b0;
    btn_down = 1'b0;
    u_vga_in.hcount = 11'd7;
    u_vga_in.vcount = 11'd9;
    u_vga_in.hsync  = 1'b1;
    u_vga_in.vsync  = 1'b1;
    u_vga_in.hblnk  = 1'b0;
    u_vga_in.vblnk  = 1'b0;
    u_vga_in.rgb    = 12'h00f;
    step(2);

    // Reset state
    chk("rst_hcount", 32'(u_vga_out.hcount), 32'd0);
    chk("rst_rgb",    32'(u_vga_out.rgb),    32'd0);
    chk("rst_hsync",  32'(u_vga_out.hsync),  32'd0);
    chk("rst_y",      32'(paddle_y),         32'd250);
    rst = 1'b0;
    u_vga_in.hsync = 1'b0;
    u_vga_in.vsync = 1'b0;

    // Pixel bounds at paddle_y = 250 on a blue background
    set_px(11'd30, 11'd250); step(1);
    chk("px_30_250", 32'(u_vga_out.rgb), 32'hfff);
    chk("px_hcount", 32'(u_vga_out.hcount), 32'd30);
    chk("px_vcount", 32'(u_vga_out.vcount), 32'd250);
    set_px(11'd45, 11'd250); #2;
    chk("px_latency", 32'(u_vga_out.rgb), 32'hfff);
    step(1);
    chk("px_45_250", 32'(u_vga_out.rgb), 32'h00f);
    set_px(11'd44, 11'd349); step(1);
    chk("px_44_349", 32'(u_vga_out.rgb), 32'hfff);
    set_px(11'd30, 11'd350); step(1);
    chk("px_30_350", 32'(u_vga_out.rgb), 32'h00f);
    set_px(11'd29, 11'd300); step(1);
    chk("px_29_300", 32'(u_vga_out.rgb), 32'h00f);
    set_px(11'd35, 11'd300); u_vga_in.hblnk = 1'b1; step(1);
    chk("px_hblnk", 32'(u_vga_out.rgb), 32'h00f);
    chk("px_hblnk_pass", 32'(u_vga_out.hblnk), 32'd1);
    u_vga_in.hblnk = 1'b0;
    set_px(11'd0, 11'd0);

    // Acceleration holding up from 250
    btn_up = 1'b1; step(3);
    tick(); chk("acc_t1", 32'(paddle_y), 32'd246);
    tick(); chk("acc_t2", 32'(paddle_y), 32'd242);
    tick(); chk("acc_t3", 32'(paddle_y), 32'd238);
    tick(); chk("acc_t4", 32'(paddle_y), 32'd234);
    tick(); chk("acc_t5", 32'(paddle_y), 32'd226);
    for (int i = 6; i <= 12; i++) tick();
    for (int i = 13; i <= 15; i++) begin
      r_prev = paddle_y;
      tick();
      chk("acc_sat16", 32'(paddle_y), 32'(r_prev) - 32'd16);
    end

    // Bottom clamp
    btn_up = 1'b0; btn_down = 1'b1; step(3);
    for (int i = 0; i < 40; i++) tick();
    chk("bot_clamp", 32'(paddle_y), 32'd500);
    tick(); chk("bot_hold1", 32'(paddle_y), 32'd500);
    tick(); chk("bot_hold2", 32'(paddle_y), 32'd500);

    // Both buttons: no motion
    btn_up = 1'b1; step(3);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("both_hold", 32'(paddle_y), 32'd500);
    end
    btn_down = 1'b0; step(3);
    tick(); chk("both_release", 32'(paddle_y), 32'd496);
    tick(); chk("up_again", 32'(paddle_y), 32'd492);

    // Reset mid-frame while moving
    u_vga_in.hcount = 11'd100; u_vga_in.vcount = 11'd100;
    u_vga_in.hsync = 1'b1; u_vga_in.vsync = 1'b1;
    u_vga_in.hblnk = 1'b1; u_vga_in.rgb = 12'habc;
    rst = 1'b1; step(1);
    chk("mrst_hcount", 32'(u_vga_out.hcount), 32'd0);
    chk("mrst_vcount", 32'(u_vga_out.vcount), 32'd0);
    chk("mrst_sync",   32'({u_vga_out.hsync, u_vga_out.vsync}), 32'd0);
    chk("mrst_blnk",   32'({u_vga_out.hblnk, u_vga_out.vblnk}), 32'd0);
    chk("mrst_rgb",    32'(u_vga_out.rgb), 32'd0);
    chk("mrst_y",      32'(paddle_y), 32'd250);
    rst = 1'b0;
    u_vga_in.hsync = 1'b0; u_vga_in.vsync = 1'b0;
    u_vga_in.hblnk = 1'b0; u_vga_in.rgb = 12'h00f;
    step(3);
    tick(); chk("mrst_speed4", 32'(paddle_y), 32'd246);

    // Top clamp: single-tick taps keep speed at 4, walk down to 2 then clamp
    btn_up = 1'b0; step(3); tick();
    for (int i = 0; i < 61; i++) begin
      btn_up = 1'b1; step(3); tick();
      btn_up = 1'b0; step(3); tick();
    end
    chk("top_at2", 32'(paddle_y), 32'd2);
    btn_up = 1'b1; step(3);
    tick(); chk("top_clamp", 32'(paddle_y), 32'd0);
    tick(); chk("top_hold", 32'(paddle_y), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
